// File: rtl/ps2_keypad_calc_if.sv
// Keyboard pins and calculator outputs of ps2_keypad_calc, bundled as one bus.
// slave is the calculator side, master the keyboard/display side.
interface ps2_keypad_calc_if;
  logic              keyb_clk;
  logic              serial_stream;
  logic [7:0]        out;
  logic              out_valid;
  logic signed [5:0] ss;
  logic              ss_valid;
  logic              err;

  modport slave (
    input  keyb_clk,
    input  serial_stream,
    output out,
    output out_valid,
    output ss,
    output ss_valid,
    output err
  );

  modport master (
    output keyb_clk,
    output serial_stream,
    input  out,
    input  out_valid,
    input  ss,
    input  ss_valid,
    input  err
  );
endinterface

// File: rtl/ps2_keypad_calc.sv
// PS/2 keyboard receiver, make/break decoder and single-digit add/subtract calculator.
// Optional macro PS2_PARITY_CHECK_EN drops frames that fail odd parity.
module ps2_keypad_calc #(
  parameter int SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              reset,
  ps2_keypad_calc_if.slave bus
);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {WAIT_A, WAIT_OP, WAIT_B, WAIT_ENT} calc_state_t;
  typedef enum logic [2:0] {K_DIGIT, K_PLUS, K_MINUS, K_ENTER, K_UNKNOWN} key_t;

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;

  function automatic key_t key_class(input logic [7:0] code);
    key_t k;
    case (code)
      8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
      8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D: k = K_DIGIT;
      8'h7C:                            k = K_PLUS;
      8'h84:                            k = K_MINUS;
      8'h79:                            k = K_ENTER;
      default:                          k = K_UNKNOWN;
    endcase
    return k;
  endfunction

  function automatic logic [3:0] key_digit(input logic [7:0] code);
    logic [3:0] d;
    case (code)
      8'h69:   d = 4'd1;
      8'h72:   d = 4'd2;
      8'h7A:   d = 4'd3;
      8'h6B:   d = 4'd4;
      8'h73:   d = 4'd5;
      8'h74:   d = 4'd6;
      8'h6C:   d = 4'd7;
      8'h75:   d = 4'd8;
      8'h7D:   d = 4'd9;
      default: d = 4'd0;
    endcase
    return d;
  endfunction

  // Operands are 0..9, so 6-bit signed holds every result without saturation.
  function automatic logic signed [5:0] calc_result(input logic [3:0] a,
                                                    input logic [3:0] b,
                                                    input logic       sub);
    logic signed [5:0] sa;
    logic signed [5:0] sb;
    sa = signed'({2'b00, a});
    sb = signed'({2'b00, b});
    return sub ? (sa - sb) : (sa + sb);
  endfunction

  // ---- stage p0: synchronise keyboard clock/data, detect rising edge ----
  logic [SYNC_STAGES-1:0] kclk_sync_p0;
  logic [SYNC_STAGES-1:0] data_sync_p0;
  logic                   kclk_prev_p0;
  logic                   strobe;
  logic                   bit_in;

  // Synchronisers reset high (PS/2 idle level) so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      kclk_sync_p0 <= '1;
      data_sync_p0 <= '1;
      kclk_prev_p0 <= 1'b1;
    end else begin
      kclk_sync_p0 <= {kclk_sync_p0[SYNC_STAGES-2:0], bus.keyb_clk};
      data_sync_p0 <= {data_sync_p0[SYNC_STAGES-2:0], bus.serial_stream};
      kclk_prev_p0 <= kclk_sync_p0[SYNC_STAGES-1];
    end
  end

  assign strobe = kclk_sync_p0[SYNC_STAGES-1] & ~kclk_prev_p0;
  assign bit_in = data_sync_p0[SYNC_STAGES-1];

  // ---- stage p1: frame receiver ----
  rx_state_t  rx_state, rx_next;
  logic [2:0] bit_cnt_p1;
  logic [7:0] shift_p1;
  logic       accept;
  logic       frame_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state   <= RX_IDLE;
      bit_cnt_p1 <= 3'd0;
    end else begin
      rx_state <= rx_next;
      if (strobe) begin
        if (rx_state == RX_DATA) bit_cnt_p1 <= bit_cnt_p1 + 3'd1;
        else                     bit_cnt_p1 <= 3'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (strobe && rx_state == RX_DATA) shift_p1 <= {bit_in, shift_p1[7:1]};
  end

`ifdef PS2_PARITY_CHECK_EN
  logic parity_p1;
  always_ff @(posedge clk) begin
    if (strobe && rx_state == RX_PARITY) parity_p1 <= bit_in;
  end
  assign frame_ok = ^{shift_p1, parity_p1};
`else
  assign frame_ok = 1'b1;
`endif

  always_comb begin
    rx_next = rx_state;
    accept  = 1'b0;
    if (strobe) begin
      case (rx_state)
        RX_IDLE:   if (!bit_in) rx_next = RX_DATA;
        RX_DATA:   if (bit_cnt_p1 == 3'd7) rx_next = RX_PARITY;
        RX_PARITY: rx_next = RX_STOP;
        RX_STOP: begin
          rx_next = RX_IDLE;
          accept  = bit_in & frame_ok;
        end
        default:   rx_next = RX_IDLE;
      endcase
    end
  end

  // ---- stage p2: byte output and make/break decode ----
  logic       brk_p2;
  logic       make_evt;
  key_t       key;
  logic [3:0] digit;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out       <= 8'h00;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= accept;
      if (accept) bus.out <= shift_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      brk_p2 <= 1'b0;
    end else if (bus.out_valid) begin
      if (bus.out == CODE_BREAK) brk_p2 <= 1'b1;
      else if (brk_p2)           brk_p2 <= 1'b0;
    end
  end

  assign make_evt = bus.out_valid && !brk_p2 &&
                    (bus.out != CODE_BREAK) && (bus.out != CODE_EXT);
  assign key      = key_class(bus.out);
  assign digit    = key_digit(bus.out);

  // ---- stage p3: calculator ----
  calc_state_t calc_state, calc_next;
  logic [3:0]  a_p3, b_p3;
  logic        sub_p3;
  logic        load_a, load_b, load_op, load_ss;
  logic        set_err, clr_err, clr_ssv;

  always_comb begin
    calc_next = calc_state;
    load_a    = 1'b0;
    load_b    = 1'b0;
    load_op   = 1'b0;
    load_ss   = 1'b0;
    set_err   = 1'b0;
    clr_err   = 1'b0;
    clr_ssv   = 1'b0;
    if (make_evt) begin
      // Any unexpected key class aborts the calculation back to WAIT_A.
      set_err   = 1'b1;
      clr_ssv   = 1'b1;
      calc_next = WAIT_A;
      case (calc_state)
        WAIT_A: if (key == K_DIGIT) begin
          set_err   = 1'b0;
          clr_err   = 1'b1;
          load_a    = 1'b1;
          calc_next = WAIT_OP;
        end
        WAIT_OP: if (key == K_PLUS || key == K_MINUS) begin
          set_err   = 1'b0;
          clr_ssv   = 1'b0;
          load_op   = 1'b1;
          calc_next = WAIT_B;
        end
        WAIT_B: if (key == K_DIGIT) begin
          set_err   = 1'b0;
          clr_ssv   = 1'b0;
          load_b    = 1'b1;
          calc_next = WAIT_ENT;
        end
        WAIT_ENT: if (key == K_ENTER) begin
          set_err   = 1'b0;
          clr_ssv   = 1'b0;
          load_ss   = 1'b1;
          calc_next = WAIT_A;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      calc_state   <= WAIT_A;
      bus.ss       <= '0;
      bus.ss_valid <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      calc_state <= calc_next;
      if (load_ss) begin
        bus.ss       <= calc_result(a_p3, b_p3, sub_p3);
        bus.ss_valid <= 1'b1;
      end else if (clr_ssv) begin
        bus.ss_valid <= 1'b0;
      end
      if (set_err)      bus.err <= 1'b1;
      else if (clr_err) bus.err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load_a)  a_p3   <= digit;
    if (load_b)  b_p3   <= digit;
    if (load_op) sub_p3 <= (key == K_MINUS);
  end

endmodule

// File: tb/tb_ps2_keypad_calc.sv
// Directed bench for ps2_keypad_calc: serialises PS/2 frames and checks byte
// output, key decode and calculator results against hand-computed values.
module tb_ps2_keypad_calc;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;
  int   pulses      = 0;
  int   pulse_base  = 0;

  always #5 clk = ~clk;

  ps2_keypad_calc_if bus ();

  ps2_keypad_calc #(.SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Counts every clk cycle out_valid is high, so one frame must add exactly 1.
  always @(negedge clk) if (bus.out_valid === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    bus.serial_stream = v;
    repeat (10) @(posedge clk);
    bus.keyb_clk = 1'b0;
    repeat (20) @(posedge clk);
    bus.keyb_clk = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b);
    send_bit(stop);
    bus.serial_stream = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic make(input logic [7:0] b);
    send_frame(b, 1'b1);
  endtask

  task automatic press(input logic [7:0] b);
    send_frame(b, 1'b1);
    send_frame(8'hF0, 1'b1);
    send_frame(b, 1'b1);
  endtask

  task automatic check_calc(input string tag, input logic [5:0] exp_ss,
                            input logic exp_v, input logic exp_err);
    check({tag, "_ss"}, {26'd0, $unsigned(bus.ss)}, {26'd0, exp_ss});
    check({tag, "_ss_valid"}, {31'd0, bus.ss_valid}, {31'd0, exp_v});
    check({tag, "_err"}, {31'd0, bus.err}, {31'd0, exp_err});
  endtask

  initial begin
    reset             = 1'b1;
    bus.keyb_clk      = 1'b1;
    bus.serial_stream = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out", {24'd0, bus.out}, 32'h00);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_calc("rst", 6'd0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (4) @(posedge clk);

    // Single 0x73 frame: one out_valid pulse of one clk.
    pulse_base = pulses;
    make(8'h73);
    check("f73_out", {24'd0, bus.out}, 32'h73);
    check("f73_pulses", pulses - pulse_base, 32'd1);

    // Finish the key: release 5, then + 4 ENTER -> 9.
    pulse_base = pulses;
    make(8'hF0);
    make(8'h73);
    check("rel_out", {24'd0, bus.out}, 32'h73);
    press(8'h7C);
    press(8'h6B);
    press(8'h79);
    check("add_pulses", pulses - pulse_base, 32'd11);
    check_calc("add", 6'd9, 1'b1, 1'b0);

    // 5 - 4 = 1; first digit clears ss_valid but keeps ss.
    make(8'h73);
    check_calc("newcalc", 6'd9, 1'b0, 1'b0);
    make(8'hF0);
    make(8'h73);
    press(8'h84);
    press(8'h6B);
    press(8'h79);
    check_calc("sub", 6'b000001, 1'b1, 1'b0);

    // 4 - 5 = -1, makes only.
    make(8'h6B);
    make(8'h84);
    make(8'h73);
    make(8'h79);
    check_calc("neg", 6'b111111, 1'b1, 1'b0);

    // Unknown key in WAIT_OP sets err; next digit in WAIT_A clears it.
    press(8'h73);
    make(8'h25);
    check_calc("unk", 6'b111111, 1'b0, 1'b1);
    make(8'hF0);
    make(8'h25);
    check("unk_rel_err", {31'd0, bus.err}, 32'd1);
    make(8'h6B);
    check("clr_err", {31'd0, bus.err}, 32'd0);
    make(8'h7C);
    make(8'h73);
    make(8'h79);
    check_calc("after_err", 6'd9, 1'b1, 1'b0);

    // 0xE0 prefix ignored: 2 - 9 = -7.
    make(8'h72);
    make(8'hE0);
    make(8'h84);
    make(8'h7D);
    make(8'h79);
    check_calc("ext", 6'b111001, 1'b1, 1'b0);

    // Bad stop bit in WAIT_B: frame dropped, then 4 + 7 = 11.
    make(8'h6B);
    make(8'h7C);
    pulse_base = pulses;
    send_frame(8'h73, 1'b0);
    check("badstop_pulses", pulses - pulse_base, 32'd0);
    check("badstop_out", {24'd0, bus.out}, 32'h7C);
    make(8'h6C);
    make(8'h79);
    check_calc("badstop", 6'd11, 1'b1, 1'b0);

    // Reset between data bits 3 and 4 of a 0x73 frame.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("midrst_out", {24'd0, bus.out}, 32'h00);
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_calc("midrst", 6'd0, 1'b0, 1'b0);
    reset             = 1'b0;
    bus.serial_stream = 1'b1;
    repeat (4) @(posedge clk);
    pulse_base = pulses;
    make(8'h69);
    check("postrst_out", {24'd0, bus.out}, 32'h69);
    check("postrst_pulses", pulses - pulse_base, 32'd1);
    make(8'h7C);
    make(8'h72);
    make(8'h79);
    check_calc("postrst", 6'd3, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
